// File: rtl/my_alu_pkg.sv
// my_alu_pkg: opcodes, condition-code bit positions and masks
// shared by the my_alu_ccr datapath ALU and its core.
package my_alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOTA = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_ADC  = 3'b110;
  localparam logic [2:0] OP_SBC  = 3'b111;

  localparam int CCR_C = 3;
  localparam int CCR_V = 2;
  localparam int CCR_N = 1;
  localparam int CCR_Z = 0;

  localparam logic [3:0] CCR_C_M = 4'b1000;
  localparam logic [3:0] CCR_V_M = 4'b0100;
  localparam logic [3:0] CCR_N_M = 4'b0010;
  localparam logic [3:0] CCR_Z_M = 4'b0001;

  // Opcodes 100-111 produce and consume carry.
  function automatic logic is_arith(
    input logic [2:0] op
  );
    return op[2];
  endfunction

endpackage

// File: rtl/my_alu_core.sv
// my_alu_core: combinational ALU, (op, A, B, carry-in, old C/V)
// to (result, next C, V, N, Z).
module my_alu_core
  import my_alu_pkg::*;
#(
  parameter int OP_SIZE = 4
) (
  input  logic [2:0]         op_i,
  input  logic [OP_SIZE-1:0] a_i,
  input  logic [OP_SIZE-1:0] b_i,
  input  logic               cin_i,
  input  logic               c_i,
  input  logic               v_i,
  output logic [OP_SIZE-1:0] r_o,
  output logic               c_o,
  output logic               v_o,
  output logic               n_o,
  output logic               z_o
);

  localparam int W   = OP_SIZE;
  localparam int MSB = OP_SIZE - 1;

  logic       cin_eff;
  logic [W:0] sum;
  logic [W:0] dif;

  // Carry/borrow only feeds ADC/SBC; bit W is carry or borrow.
  always_comb begin
    cin_eff = (op_i == OP_ADC || op_i == OP_SBC) ? cin_i : 1'b0;
    sum = {1'b0, a_i} + {1'b0, b_i}
        + {{W{1'b0}}, cin_eff};
    dif = {1'b0, a_i} - {1'b0, b_i}
        - {{W{1'b0}}, cin_eff};
  end

  // Result select and flag generation.
  always_comb begin
    r_o = '0;
    c_o = c_i;
    v_o = v_i;
    unique case (op_i)
      OP_AND:  r_o = a_i & b_i;
      OP_OR:   r_o = a_i | b_i;
      OP_XOR:  r_o = a_i ^ b_i;
      OP_NOTA: r_o = ~a_i;
      OP_ADD, OP_ADC: begin
        r_o = sum[W-1:0];
        c_o = sum[W];
        v_o = (a_i[MSB] == b_i[MSB])
           && (r_o[MSB] != a_i[MSB]);
      end
      OP_SUB, OP_SBC: begin
        r_o = dif[W-1:0];
        c_o = dif[W];
        v_o = (a_i[MSB] != b_i[MSB])
           && (r_o[MSB] != a_i[MSB]);
      end
    endcase
    n_o = r_o[MSB];
    z_o = (r_o == '0);
  end

endmodule

// File: rtl/my_alu_ccr.sv
// my_alu_ccr: two-stage valid/ready ALU with persistent CVNZ
// condition codes and carry forwarding from stage 1.
module my_alu_ccr
  import my_alu_pkg::*;
#(
  parameter int OP_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [OP_SIZE-1:0] A,
  input  logic [OP_SIZE-1:0] B,
  input  logic               clr_ccr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_SIZE-1:0] R,
  output logic [3:0]         CCR
);

  logic               s1_valid_q, s1_valid_d;
  logic [OP_SIZE-1:0] s1_r_q, s1_r_d;
  logic [3:0]         s1_f_q, s1_f_d;
  logic               s1_arith_q, s1_arith_d;
  logic               out_valid_q, out_valid_d;
  logic [OP_SIZE-1:0] r_q, r_d;
  logic [3:0]         ccr_q, ccr_d;

  logic               out_free;
  logic               in_fire;
  logic               commit;
  logic               cin;
  logic [OP_SIZE-1:0] core_r;
  logic               core_c, core_v, core_n, core_z;

  // Handshake and forwarded carry for the op being accepted.
  always_comb begin
    out_free = !out_valid_q || out_ready;
    in_ready = !rst && (!s1_valid_q || out_free);
    in_fire  = in_valid && in_ready;
    commit   = s1_valid_q && out_free;
    if (s1_valid_q && s1_arith_q)
      cin = s1_f_q[CCR_C];
    else
      cin = clr_ccr ? 1'b0 : ccr_q[CCR_C];
  end

  my_alu_core #(
    .OP_SIZE (OP_SIZE)
  ) u_core (
    .op_i  (op),
    .a_i   (A),
    .b_i   (B),
    .cin_i (cin),
    .c_i   (ccr_q[CCR_C]),
    .v_i   (ccr_q[CCR_V]),
    .r_o   (core_r),
    .c_o   (core_c),
    .v_o   (core_v),
    .n_o   (core_n),
    .z_o   (core_z)
  );

  // Next state: stage 1 capture, output commit, CCR update.
  // Logic ops take C/V from the CCR at commit so ordering holds.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_r_d      = s1_r_q;
    s1_f_d      = s1_f_q;
    s1_arith_d  = s1_arith_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_r_d     = core_r;
      s1_f_d     = {core_c, core_v, core_n, core_z};
      s1_arith_d = is_arith(op);
    end else if (commit) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_free ? s1_valid_q : out_valid_q;
    r_d         = commit ? s1_r_q : r_q;

    ccr_d = clr_ccr ? 4'b0000 : ccr_q;
    if (commit) begin
      ccr_d[CCR_N] = s1_f_q[CCR_N];
      ccr_d[CCR_Z] = s1_f_q[CCR_Z];
      if (s1_arith_q) begin
        ccr_d[CCR_C] = s1_f_q[CCR_C];
        ccr_d[CCR_V] = s1_f_q[CCR_V];
      end
    end
  end

  // Pipeline and CCR registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_r_q      <= '0;
      s1_f_q      <= '0;
      s1_arith_q  <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      ccr_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_r_q      <= s1_r_d;
      s1_f_q      <= s1_f_d;
      s1_arith_q  <= s1_arith_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      ccr_q       <= ccr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign R         = r_q;
  assign CCR       = ccr_q;

endmodule

// File: tb/tb_my_alu_ccr.sv
// tb_my_alu_ccr: directed vectors with a scoreboard queue;
// a monitor pops and compares on each output handshake.
module tb_my_alu_ccr;
  import my_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'b000;
  logic [3:0] A = 4'b0000;
  logic [3:0] B = 4'b0000;
  logic       clr_ccr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] R;
  logic [3:0] CCR;

  typedef struct {
    logic [3:0] r;
    logic [3:0] ccr;
    bit         lat;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  my_alu_ccr #(.OP_SIZE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .clr_ccr   (clr_ccr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .CCR       (CCR)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Present one op; push its expected result when accepted.
  task automatic issue(input string nm,
                       input logic [2:0] o,
                       input logic [3:0] a,
                       input logic [3:0] b,
                       input logic [3:0] er,
                       input logic [3:0] ec,
                       input bit lat,
                       output int waits);
    bit done;
    exp_t e;
    done = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    op = o;
    A = a;
    B = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.r = er;
        e.ccr = ec;
        e.lat = lat;
        e.cyc = cyc;
        e.name = nm;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          checks++;
          errors++;
          $display("FAIL %s_accept: in_ready stuck 0", nm);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: compare on handshake, check stability under stall.
  initial begin
    bit stall_prev;
    logic [7:0] held;
    exp_t e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        stall_prev = 1'b0;
      end else if (!out_ready) begin
        if (stall_prev)
          chk("stall_hold", {R, CCR}, held);
        held = {R, CCR};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got %b want none",
                   {R, CCR});
        end else begin
          e = sb.pop_front();
          chk({e.name, "_R_CCR"}, {R, CCR}, {e.r, e.ccr});
          if (e.lat)
            chk({e.name, "_latency"},
                8'(cyc - e.cyc), 8'd2);
        end
      end
    end
  end

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({nm, "_drained"}, 8'(sb.size()), 8'd0);
  endtask

  initial begin
    int w;
    #1 rst = 1'b1;
    #2;
    chk("rst_R", {4'b0, R}, 8'h00);
    chk("rst_CCR", {4'b0, CCR}, 8'h00);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_in_ready", {7'b0, in_ready}, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue("add_cv", OP_ADD, 4'b1100, 4'b1000,
          4'b0100, 4'b1100, 1'b0, w);
    issue("xor", OP_XOR, 4'b1010, 4'b0110,
          4'b1100, 4'b1110, 1'b1, w);
    issue("add_ovf", OP_ADD, 4'b0111, 4'b0001,
          4'b1000, 4'b0110, 1'b0, w);
    issue("add_carry", OP_ADD, 4'b1111, 4'b0001,
          4'b0000, 4'b1001, 1'b0, w);
    issue("adc_fwd", OP_ADC, 4'b0000, 4'b0000,
          4'b0001, 4'b0000, 1'b0, w);
    chk("adc_fwd_gap", 8'(w), 8'd0);
    issue("sub", OP_SUB, 4'b0011, 4'b0101,
          4'b1110, 4'b1010, 1'b0, w);
    issue("sbc_fwd", OP_SBC, 4'b0101, 4'b0001,
          4'b0011, 4'b0000, 1'b0, w);
    chk("sbc_fwd_gap", 8'(w), 8'd0);
    drain("stream");

    out_ready = 1'b0;
    issue("bp_or", OP_OR, 4'b0101, 4'b0010,
          4'b0111, 4'b0000, 1'b0, w);
    issue("bp_add", OP_ADD, 4'b0110, 4'b0101,
          4'b1011, 4'b0110, 1'b0, w);
    @(negedge clk);
    chk("bp_in_ready", {7'b0, in_ready}, 8'h00);
    chk("bp_out_valid", {7'b0, out_valid}, 8'h01);
    fork
      issue("bp_and", OP_AND, 4'b1011, 4'b0110,
            4'b0010, 4'b0100, 1'b0, w);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    issue("nota", OP_NOTA, 4'b1010, 4'b1111,
          4'b0101, 4'b0100, 1'b0, w);
    drain("bp");

    out_ready = 1'b0;
    issue("pre_rst_add", OP_ADD, 4'b1000, 4'b1000,
          4'b0000, 4'b1101, 1'b0, w);
    issue("pre_rst_adc", OP_ADC, 4'b0001, 4'b0001,
          4'b0011, 4'b0000, 1'b0, w);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_R", {4'b0, R}, 8'h00);
    chk("midrst_CCR", {4'b0, CCR}, 8'h00);
    chk("midrst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("midrst_in_ready", {7'b0, in_ready}, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    issue("adc_after_rst", OP_ADC, 4'b0010, 4'b0011,
          4'b0101, 4'b0000, 1'b0, w);

    issue("add_pre_clr", OP_ADD, 4'b1100, 4'b1000,
          4'b0100, 4'b1100, 1'b0, w);
    issue("and_clr", OP_AND, 4'b0101, 4'b1010,
          4'b0000, 4'b0001, 1'b0, w);
    clr_ccr = 1'b1;
    @(posedge clk);
    #1 clr_ccr = 1'b0;
    drain("clr");
    repeat (2) @(posedge clk);
    #1;
    chk("ccr_persist", {4'b0, CCR}, 8'h01);
    chk("idle_out_valid", {7'b0, out_valid}, 8'h00);
    clr_ccr = 1'b1;
    @(posedge clk);
    #1 clr_ccr = 1'b0;
    chk("idle_clr", {4'b0, CCR}, 8'h00);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/my_alu_ccr.md
# my_alu_ccr

Parametrised, pipelined successor to the team's single-operation flag units. Performs one of eight logic/arithmetic operations on two `OP_SIZE`-bit operands and commits the result together with a persistent 4-bit condition code register (CVNZ) two cycles after acceptance. Input and output use valid/ready handshakes, and carry-consuming operations see the carry of the previous arithmetic operation in program order. It serves as the datapath ALU for the team's small processor exercises.

## Interface
- `OP_SIZE`, 4: operand/result width in bits, ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand/opcode presented.
- `in_ready`  out  1  block accepts this cycle; transfer on `in_valid && in_ready`.
- `op`  in  3  opcode (see Operation).
- `A`, `B`  in  `OP_SIZE`  operands.
- `clr_ccr`  in  1  synchronous CCR clear request.
- `out_valid`  out  1  `R`/`CCR` hold a committed result.
- `out_ready`  in  1  consumer takes result; transfer on `out_valid && out_ready`.
- `R`  out  `OP_SIZE`  committed result.
- `CCR`  out  4  condition codes, bit 3..0 = C,V,N,Z.

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOT A (B ignored), 100 ADD A+B, 101 SUB A−B, 110 ADC A+B+C, 111 SBC A−B−C.
- Arithmetic is modulo 2^`OP_SIZE`; carry is bit `OP_SIZE` of the (`OP_SIZE`+1)-bit sum.
- N = MSB of result, Z = (result == 0) for all ops.
- Logic ops (000–011): C and V unchanged.
- ADD/ADC: C = carry out; V = both operands' MSBs equal and result MSB differs.
- SUB/SBC: C = borrow (1 when unsigned A < B + Cin); V = A/B MSBs differ and result MSB differs from A's.
- Carry-in for ADC/SBC = C produced by the most recent *accepted* arithmetic op (100–111). If that op is still in stage 1, its C is forwarded; otherwise CCR.C is used. No stall is ever inserted for this dependency.
- `clr_ccr` clears all CCR bits at the next edge. If a commit occurs on that same edge, the commit writes N, Z (and C, V for arithmetic ops); all remaining bits are 0. Logic ops committed on a clear edge therefore leave C = V = 0. A clear also sets the forwarding carry to 0 for ops accepted on that edge or later, unless an arithmetic op is in stage 1.
- Pipeline: stage 1 holds registered result + next flags (`s1_valid`). Stage 2 is the output register `R`/`CCR`/`out_valid`.

## Timing
- Reset (async, immediate): `R` = 0, `CCR` = 0000, `out_valid` = 0, stage 1 empty. `in_ready` = 0 while `rst` is high.
- Latency: input accepted at edge k is in stage 1 after k. It commits to `R`/`CCR`, with `out_valid` = 1, after edge k+1 if the output is free.
- Output is free when `!out_valid || out_ready`. Stage 1 advances only when the output is free.
- `in_ready` = `!rst && (!s1_valid || output free)`, combinational.
- Throughput is one op per cycle with `out_ready` held high.
- `out_valid`, `R` and `CCR` are held stable while `out_valid && !out_ready`.
- `CCR` changes only on commit or `clr_ccr`. `CCR` persists after the output handshake; `out_valid` drops if nothing new commits.
- Reset mid-operation discards stage 1 and the output register; no partial commit.

## Structure
- Package `my_alu_pkg`: opcode constants, CCR bit indices (C=3, V=2, N=1, Z=0) and masks (1000, 0100, 0010, 0001).
- Sub-module `my_alu_core`: purely combinational, (op, A, B, cin, CCR.C/V) → (result, next C, V, N, Z). It is instantiated once in stage 1.
- Top level contains the stage registers, handshake logic, carry forwarding and clear handling.

## Test plan
All values below use `OP_SIZE` = 4 and `out_ready` = 1 unless stated.
- XOR A=1010, B=0110, starting from CCR=1100 → R=1100, CCR=1110, 2 cycles after acceptance.
- ADD 0111+0001 → R=1000, CCR=0110. ADD 1111+0001 → R=0000, CCR=1001.
- Back-to-back: ADD 1111+0001, then ADC 0000+0000 on the next cycle → second R=0001 via the forwarded carry, CCR=0000. No `in_ready` gap.
- SUB 0011−0101 → R=1110, CCR=1010. SBC 0101−0001 with C=1 → R=0011, CCR=0000.
- Backpressure: hold `out_ready`=0 for 3 cycles while issuing 3 ops. The first two are accepted, then `in_ready`=0, and the outputs stay stable. On release, results appear in order with none lost.
- Reset asserted mid-cycle with both stages full → outputs go to 0 immediately. After deassertion the first new op yields the correct result, with C taken as 0 for ADC.
- `clr_ccr` on the same edge as committing an AND with result 0000, from CCR=1100 → CCR=0001.
